// File: rtl/md_unit_if.sv
// Request/response bundle between EX-stage control and the multiply/divide unit.
// Control drives the request side; the unit returns busy/done and the HI/LO registers.
interface md_unit_if;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (output start, md_op, a, b, input busy, done, hi, lo);
   modport slave  (input start, md_op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle mult/div unit holding HI/LO. The unit latches the operands at issue,
// counts down a fixed latency, then commits the result, drops busy and pulses done.
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic     clk,
   input  logic     reset,
   md_unit_if.slave md
);
   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } md_req_t;

   typedef enum logic {S_IDLE, S_BUSY} st_e;

   st_e         st_q, st_d;
   logic [CW-1:0] cnt_q, cnt_d;
   md_req_t     req_q, req_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic        done_q, done_d;

   logic [63:0] prod_s, prod_u, res;
   logic [31:0] dvs, a_mag, b_mag, q_mag, r_mag, q_s, r_s, q_u, r_u;
   logic        div_zero, is_div;

   // Signed divide works on magnitudes so 0x8000_0000 / -1 yields 0x8000_0000 without overflow.
   always_comb begin
      prod_s   = {{32{req_q.a[31]}}, req_q.a} * {{32{req_q.b[31]}}, req_q.b};
      prod_u   = {32'b0, req_q.a} * {32'b0, req_q.b};
      div_zero = (req_q.b == 32'd0);
      dvs      = div_zero ? 32'd1 : req_q.b;
      a_mag    = req_q.a[31] ? -req_q.a : req_q.a;
      b_mag    = req_q.b[31] ? -req_q.b : dvs;
      q_mag    = a_mag / b_mag;
      r_mag    = a_mag % b_mag;
      q_s      = (req_q.a[31] ^ req_q.b[31]) ? -q_mag : q_mag;
      r_s      = req_q.a[31] ? -r_mag : r_mag;
      q_u      = req_q.a / dvs;
      r_u      = req_q.a % dvs;
      is_div   = (req_q.op == OP_DIV) || (req_q.op == OP_DIVU);
      case (req_q.op)
         OP_MULT:  res = prod_s;
         OP_MULTU: res = prod_u;
         OP_DIV:   res = {r_s, q_s};
         default:  res = {r_u, q_u};
      endcase
   end

   always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      req_d  = req_q;
      hi_d   = hi_q;
      lo_d   = lo_q;
      done_d = 1'b0;
      case (st_q)
         S_IDLE: begin
            if (md.start) begin
               case (md.md_op)
                  OP_MULT, OP_MULTU: begin
                     req_d = '{op: md.md_op, a: md.a, b: md.b};
                     cnt_d = CW'(MULT_CYCLES - 1);
                     st_d  = S_BUSY;
                  end
                  OP_DIV, OP_DIVU: begin
                     req_d = '{op: md.md_op, a: md.a, b: md.b};
                     cnt_d = CW'(DIV_CYCLES - 1);
                     st_d  = S_BUSY;
                  end
                  OP_MTHI: hi_d = md.a;
                  OP_MTLO: lo_d = md.a;
                  default: ;
               endcase
            end
         end
         S_BUSY: begin
            if (cnt_q == '0) begin
               st_d   = S_IDLE;
               done_d = 1'b1;
               // Divide by zero still takes full latency but leaves HI/LO untouched.
               if (!(is_div && div_zero)) begin
                  hi_d = res[63:32];
                  lo_d = res[31:0];
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: st_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         st_q   <= S_IDLE;
         cnt_q  <= '0;
         req_q  <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         done_q <= 1'b0;
      end else begin
         st_q   <= st_d;
         cnt_q  <= cnt_d;
         req_q  <= req_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         done_q <= done_d;
      end
   end

   assign md.busy = (st_q == S_BUSY);
   assign md.done = done_q;
   assign md.hi   = hi_q;
   assign md.lo   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: vector table, hand-written corner sequences, then random ops
// checked against an arithmetic reference model of HI/LO.
module tb_md_unit;
   localparam int MC = 5;
   localparam int DC = 10;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   md_unit_if mif ();
   md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (.clk(clk), .reset(reset), .md(mif));

   int checks = 0;
   int errors = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic int latency(input logic [2:0] op);
      if (op <= 3'd1) return MC;
      if (op <= 3'd3) return DC;
      return 0;
   endfunction

   // Reference model: plain 64-bit arithmetic on the operation's definition.
   task automatic model_step(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] p;
      longint q, r;
      case (op)
         3'd0: begin p = 64'(longint'($signed(x)) * longint'($signed(y))); m_hi = p[63:32]; m_lo = p[31:0]; end
         3'd1: begin p = {32'b0, x} * {32'b0, y}; m_hi = p[63:32]; m_lo = p[31:0]; end
         3'd2: if (y != 0) begin
            q = longint'($signed(x)) / longint'($signed(y));
            r = longint'($signed(x)) % longint'($signed(y));
            m_lo = q[31:0]; m_hi = r[31:0];
         end
         3'd3: if (y != 0) begin m_lo = x / y; m_hi = x % y; end
         3'd4: m_hi = x;
         3'd5: m_lo = x;
         default: ;
      endcase
   endtask

   // Issue one op, scramble operands while busy, check latency, done pulse and HI/LO.
   task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el, input string tag);
      int lat, cyc;
      lat = latency(op);
      @(negedge clk);
      mif.start = 1'b1; mif.md_op = op; mif.a = x; mif.b = y;
      @(negedge clk);
      mif.start = 1'b0; mif.a = $urandom; mif.b = $urandom;
      if (lat > 0) begin
         cyc = 0;
         while (mif.busy && cyc < 64) begin
            cyc++;
            chk({tag, ".no_early_done"}, 64'(mif.done), 64'd0);
            @(negedge clk);
         end
         chk({tag, ".latency"}, 64'(cyc), 64'(lat));
         chk({tag, ".done"}, 64'(mif.done), 64'd1);
      end else begin
         chk({tag, ".busy"}, 64'(mif.busy), 64'd0);
         chk({tag, ".done"}, 64'(mif.done), 64'd0);
      end
      chk({tag, ".hi"}, 64'(mif.hi), 64'(eh));
      chk({tag, ".lo"}, 64'(mif.lo), 64'(el));
      if (lat > 0) begin
         @(negedge clk);
         chk({tag, ".done_pulse"}, 64'(mif.done), 64'd0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vt[12];
      int cyc, dn;
      logic [2:0]  op;
      logic [31:0] x, y;

      vt[0]  = '{3'd0, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA};
      vt[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vt[2]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vt[3]  = '{3'd3, 32'd5,         32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vt[4]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
      vt[5]  = '{3'd3, 32'd100,       32'd7,        32'd2,         32'd14};
      vt[6]  = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
      vt[7]  = '{3'd4, 32'h1234,      32'd9,        32'h1234,      32'hFFFF_FFFD};
      vt[8]  = '{3'd5, 32'hABCD,      32'd9,        32'h1234,      32'hABCD};
      vt[9]  = '{3'd6, 32'h5555,      32'h6666,     32'h1234,      32'hABCD};
      vt[10] = '{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
      vt[11] = '{3'd2, 32'd9,         32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFEB};

      mif.start = 1'b0; mif.md_op = '0; mif.a = '0; mif.b = '0;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.busy", 64'(mif.busy), 64'd0);
      chk("rst.done", 64'(mif.done), 64'd0);
      chk("rst.hi", 64'(mif.hi), 64'd0);
      chk("rst.lo", 64'(mif.lo), 64'd0);
      reset = 1'b1;

      for (int i = 0; i < 12; i++)
         run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo, $sformatf("vec%0d", i));

      // Back-to-back: next mult accepted in the done cycle with no bubble.
      @(negedge clk);
      mif.start = 1'b1; mif.md_op = 3'd0; mif.a = 32'd6; mif.b = 32'd7;
      @(negedge clk);
      mif.start = 1'b0;
      cyc = 0;
      while (!mif.done && cyc < 64) begin cyc++; @(negedge clk); end
      chk("b2b.first_lo", 64'(mif.lo), 64'd42);
      chk("b2b.first_hi", 64'(mif.hi), 64'd0);
      chk("b2b.idle_at_done", 64'(mif.busy), 64'd0);
      mif.start = 1'b1; mif.md_op = 3'd1; mif.a = 32'h1_0000; mif.b = 32'h1_0000;
      @(negedge clk);
      mif.start = 1'b0;
      chk("b2b.accepted", 64'(mif.busy), 64'd1);
      cyc = 0;
      while (mif.busy && cyc < 64) begin cyc++; @(negedge clk); end
      chk("b2b.latency", 64'(cyc), 64'(MC));
      chk("b2b.hi", 64'(mif.hi), 64'd1);
      chk("b2b.lo", 64'(mif.lo), 64'd0);

      // mthi, then mult with a div request presented while busy: div must be ignored.
      run_op(3'd4, 32'h1234, 32'd0, 32'h1234, 32'd0, "mthi");
      @(negedge clk);
      mif.start = 1'b1; mif.md_op = 3'd0; mif.a = 32'd3; mif.b = 32'd5;
      @(negedge clk);
      mif.start = 1'b0;
      chk("ign.hi_hold", 64'(mif.hi), 64'h1234);
      @(negedge clk);
      mif.start = 1'b1; mif.md_op = 3'd2; mif.a = 32'd100; mif.b = 32'd7;
      repeat (2) @(negedge clk);
      mif.start = 1'b0;
      cyc = 0;
      while (!mif.done && cyc < 64) begin cyc++; @(negedge clk); end
      chk("ign.hi", 64'(mif.hi), 64'd0);
      chk("ign.lo", 64'(mif.lo), 64'd15);
      @(negedge clk);
      chk("ign.no_div_busy", 64'(mif.busy), 64'd0);
      chk("ign.no_div_done", 64'(mif.done), 64'd0);

      // Reset in busy cycle 3 of a div aborts it with no commit.
      run_op(3'd4, 32'h77, 32'd0, 32'h77, 32'd15, "pre_abort");
      @(negedge clk);
      mif.start = 1'b1; mif.md_op = 3'd3; mif.a = 32'd50; mif.b = 32'd3;
      @(negedge clk);
      mif.start = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk("abort.busy", 64'(mif.busy), 64'd0);
      chk("abort.hi", 64'(mif.hi), 64'd0);
      chk("abort.lo", 64'(mif.lo), 64'd0);
      dn = 0;
      for (int k = 0; k < 14; k++) begin
         if (mif.done) dn++;
         @(negedge clk);
      end
      chk("abort.no_done", 64'(dn), 64'd0);
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "ovf_div");

      // Reset and start together: reset wins.
      @(negedge clk);
      reset = 1'b0; mif.start = 1'b1; mif.md_op = 3'd0; mif.a = 32'd3; mif.b = 32'd4;
      @(negedge clk);
      reset = 1'b1; mif.start = 1'b0;
      chk("rst_start.busy", 64'(mif.busy), 64'd0);
      chk("rst_start.lo", 64'(mif.lo), 64'd0);
      dn = 0;
      for (int k = 0; k < 8; k++) begin
         if (mif.done || mif.busy) dn++;
         @(negedge clk);
      end
      chk("rst_start.quiet", 64'(dn), 64'd0);

      m_hi = '0; m_lo = '0;
      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 7));
         x  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 4))
            0:       y = 32'd0;
            1:       y = $urandom_range(1, 9);
            2:       y = 32'hFFFF_FFFF;
            default: y = $urandom;
         endcase
         model_step(op, x, y);
         run_op(op, x, y, m_hi, m_lo, $sformatf("rnd%0d_op%0d", i, op));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
